// File: rtl/sar_control_weighted.sv
// SAR ADC control FSM with programmable step weights, LSB majority averaging and saturation; strobe S+(STEPS-LSB_STEPS)+LSB_STEPS*N cycles after first sample.
// No backpressure: start_in/continuous_in are only sampled in IDLE/DONE, triggers while converting are dropped.
module sar_control_weighted #(
   parameter int MATRIX_BITS = 12,
   parameter int STEPS       = 15,
   parameter int LSB_STEPS   = 4,
   parameter int STEP_AW     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_in,
   input  logic                   continuous_in,
   input  logic [2:0]             avg_control_in,
   input  logic [3:0]             sample_cycles_in,
   input  logic                   comparator_in,
   input  logic                   wt_we_in,
   input  logic [STEP_AW-1:0]     wt_addr_in,
   input  logic [MATRIX_BITS-1:0] wt_data_in,
   output logic                   sample_out,
   output logic                   sample_out_n,
   output logic                   enable_loop_out,
   output logic                   busy_out,
   output logic [MATRIX_BITS-1:0] nswitch_out,
   output logic [MATRIX_BITS-1:0] pswitch_out,
   output logic [MATRIX_BITS-1:0] result_out,
   output logic                   conv_finished_strobe_out,
   output logic                   overflow_out
);

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

   localparam logic [STEP_AW-1:0] LAST_STEP = STEP_AW'(STEPS - 1);
   localparam logic [STEP_AW-1:0] AVG_FIRST = STEP_AW'(STEPS - LSB_STEPS);

   function automatic logic [MATRIX_BITS-1:0] default_weight(input int k);
      if (k < MATRIX_BITS)
         return MATRIX_BITS'(1) << (MATRIX_BITS - 1 - k);
      return '0;
   endfunction

   state_t                 state;
   logic [MATRIX_BITS-1:0] weight [2**STEP_AW];
   logic [MATRIX_BITS-1:0] data;
   logic [STEP_AW-1:0]     step;
   logic [4:0]             cyc;
   logic [5:0]             ones;
   logic [3:0]             scnt;
   logic [2:0]             avg_q;
   logic [3:0]             samp_q;
   logic                   ovf_q;

   logic [4:0]             n_len;
   logic [4:0]             step_len;
   logic [5:0]             ones_tot;
   logic [5:0]             thr;
   logic                   decide;
   logic                   step_end;
   logic [3:0]             s_len;
   logic [MATRIX_BITS:0]   trial;
   logic                   carry;
   logic [MATRIX_BITS-1:0] sat_trial;
   logic                   trigger;

   always_comb begin
      case (avg_q)
         3'b001:  n_len = 5'd3;
         3'b010:  n_len = 5'd7;
         3'b011:  n_len = 5'd15;
         3'b100:  n_len = 5'd31;
         default: n_len = 5'd1;
      endcase
   end

   // Single-cycle steps use the same majority rule with a length of one.
   assign step_len  = (step >= AVG_FIRST) ? n_len : 5'd1;
   assign ones_tot  = ones + 6'(comparator_in);
   assign thr       = (6'(step_len) + 6'd1) >> 1;
   assign decide    = (ones_tot >= thr);
   assign step_end  = (cyc == step_len - 5'd1);
   assign s_len     = (samp_q == 4'd0) ? 4'd1 : samp_q;
   assign trial     = {1'b0, data} + {1'b0, weight[step]};
   assign carry     = trial[MATRIX_BITS];
   assign sat_trial = carry ? '1 : trial[MATRIX_BITS-1:0];
   assign trigger   = start_in | continuous_in;

   assign sample_out               = (state == SAMPLE);
   assign sample_out_n             = ~sample_out;
   assign enable_loop_out          = (state == CONVERT);
   assign busy_out                 = (state != IDLE);
   assign conv_finished_strobe_out = (state == DONE);
   assign nswitch_out              = (state == CONVERT) ? sat_trial : data;
   assign pswitch_out              = ~nswitch_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2**STEP_AW; k++)
            weight[k] <= default_weight(k);
      end else if (wt_we_in && state == IDLE && int'(wt_addr_in) < STEPS) begin
         weight[wt_addr_in] <= wt_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         data         <= '0;
         step         <= '0;
         cyc          <= '0;
         ones         <= '0;
         scnt         <= '0;
         avg_q        <= '0;
         samp_q       <= '0;
         ovf_q        <= 1'b0;
         result_out   <= '0;
         overflow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  avg_q  <= avg_control_in;
                  samp_q <= sample_cycles_in;
                  scnt   <= '0;
                  data   <= '0;
                  ovf_q  <= 1'b0;
                  state  <= SAMPLE;
               end
            end
            SAMPLE: begin
               data <= '0;
               if (scnt == s_len - 4'd1) begin
                  step  <= '0;
                  cyc   <= '0;
                  ones  <= '0;
                  state <= CONVERT;
               end else begin
                  scnt <= scnt + 4'd1;
               end
            end
            CONVERT: begin
               if (step_end) begin
                  cyc  <= '0;
                  ones <= '0;
                  if (decide) begin
                     data <= sat_trial;
                     if (carry)
                        ovf_q <= 1'b1;
                  end
                  // Final decision is folded straight into the published result.
                  if (step == LAST_STEP) begin
                     result_out   <= decide ? sat_trial : data;
                     overflow_out <= ovf_q | (decide & carry);
                     state        <= DONE;
                  end else begin
                     step <= step + 1'b1;
                  end
               end else begin
                  cyc  <= cyc + 5'd1;
                  ones <= ones_tot;
               end
            end
            DONE: begin
               data <= '0;
               if (trigger) begin
                  avg_q  <= avg_control_in;
                  samp_q <= sample_cycles_in;
                  scnt   <= '0;
                  ovf_q  <= 1'b0;
                  state  <= SAMPLE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_control_weighted.sv
// Scoreboard bench for sar_control_weighted: stimulus pushes expected results, a negedge monitor checks each strobe.
module tb_sar_control_weighted;
   localparam int MB = 12;
   localparam int ST = 15;
   localparam int LS = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_in, continuous_in;
   logic [2:0]    avg_control_in;
   logic [3:0]    sample_cycles_in;
   logic          comparator_in;
   logic          wt_we_in;
   logic [AW-1:0] wt_addr_in;
   logic [MB-1:0] wt_data_in;
   logic          sample_out, sample_out_n, enable_loop_out, busy_out;
   logic [MB-1:0] nswitch_out, pswitch_out, result_out;
   logic          conv_finished_strobe_out, overflow_out;

   always #5 clk = ~clk;

   sar_control_weighted #(.MATRIX_BITS(MB), .STEPS(ST), .LSB_STEPS(LS), .STEP_AW(AW)) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .continuous_in(continuous_in),
      .avg_control_in(avg_control_in), .sample_cycles_in(sample_cycles_in),
      .comparator_in(comparator_in), .wt_we_in(wt_we_in), .wt_addr_in(wt_addr_in),
      .wt_data_in(wt_data_in), .sample_out(sample_out), .sample_out_n(sample_out_n),
      .enable_loop_out(enable_loop_out), .busy_out(busy_out), .nswitch_out(nswitch_out),
      .pswitch_out(pswitch_out), .result_out(result_out),
      .conv_finished_strobe_out(conv_finished_strobe_out), .overflow_out(overflow_out)
   );

   // Comparator model: accept while trial code <= input voltage, with overrides.
   logic [MB-1:0] vin;
   logic          force_one, ovr_arm, ovr_en, ovr_val;
   logic [6:0]    ovr_pat;
   int            conv_c = 0;
   int            last_len = 0;
   assign comparator_in = force_one ? 1'b1 : (ovr_en ? ovr_val : (nswitch_out <= vin));

   always @(negedge clk) begin
      if (enable_loop_out) begin
         ovr_en = ovr_arm && conv_c >= 32 && conv_c <= 38;
         if (ovr_en) ovr_val = ovr_pat[conv_c-32];
         conv_c = conv_c + 1;
      end else begin
         if (conv_c != 0) last_len = conv_c;
         conv_c = 0;
         ovr_en = 1'b0;
      end
   end

   typedef struct {
      logic [MB-1:0] res;
      logic          ovf;
      int            lat;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   int   cyc_cnt = 0;
   int   samp_start = 0;
   int   n_strobe = 0;
   int   done_sample = 0;
   int   inv_err = 0;
   logic prev_sample = 1'b0;
   logic prev_strobe = 1'b0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (sample_out_n !== ~sample_out || pswitch_out !== ~nswitch_out) inv_err++;
      if (sample_out && !prev_sample) samp_start = cyc_cnt;
      if (prev_strobe && sample_out) done_sample++;
      if (conv_finished_strobe_out) begin
         n_strobe++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: result %0h with no expectation queued", result_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", 32'(result_out), 32'(mon_e.res));
            check("overflow", 32'(overflow_out), 32'(mon_e.ovf));
            check("latency", 32'(cyc_cnt - samp_start), 32'(mon_e.lat));
         end
      end
      prev_sample = sample_out;
      prev_strobe = conv_finished_strobe_out;
   end

   task automatic wr(input int a, input logic [MB-1:0] d);
      wt_we_in = 1'b1;
      wt_addr_in = AW'(a);
      wt_data_in = d;
      @(negedge clk);
      wt_we_in = 1'b0;
   endtask

   task automatic start_conv(input logic [MB-1:0] v, input logic [3:0] s, input logic [2:0] a,
                             input logic push, input logic [MB-1:0] er, input logic eo, input int el);
      exp_t e;
      vin = v;
      sample_cycles_in = s;
      avg_control_in = a;
      if (push) begin
         e.res = er;
         e.ovf = eo;
         e.lat = el;
         exp_q.push_back(e);
      end
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic wait_strobes(input int target, input string name);
      int n = 0;
      while (n_strobe < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n_strobe < target) begin
         bad++;
         $display("FAIL %s_timeout: strobes %0d need %0d", name, n_strobe, target);
      end
   endtask

   task automatic run_conv(input logic [MB-1:0] v, input logic [3:0] s, input logic [2:0] a,
                           input logic [MB-1:0] er, input logic eo, input int el, input string name);
      int t;
      t = n_strobe + 1;
      start_conv(v, s, a, 1'b1, er, eo, el);
      wait_strobes(t, name);
      @(negedge clk);
   endtask

   int cw[ST] = '{2048, 806, 486, 295, 180, 110, 67, 41, 25, 15, 9, 6, 4, 2, 1};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int base;
      int ds0;
      rst = 1'b1; start_in = 1'b0; continuous_in = 1'b0; avg_control_in = '0;
      sample_cycles_in = 4'd1; wt_we_in = 1'b0; wt_addr_in = '0; wt_data_in = '0;
      vin = '0; force_one = 1'b0; ovr_arm = 1'b0; ovr_pat = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_result", 32'(result_out), 32'h0);
      check("rst_strobe", 32'(conv_finished_strobe_out), 32'h0);
      check("rst_overflow", 32'(overflow_out), 32'h0);
      check("rst_sample", 32'(sample_out), 32'h0);
      check("rst_sample_n", 32'(sample_out_n), 32'h1);
      check("rst_busy", 32'(busy_out), 32'h0);
      check("rst_pswitch", 32'(pswitch_out), 32'hFFF);

      // Binary weights out of reset.
      run_conv(12'hABC, 4'd1, 3'b000, 12'hABC, 1'b0, 16, "default_abc");

      // Non-binary weights; a write while busy must be dropped.
      for (int k = 0; k < ST; k++) wr(k, MB'(cw[k]));
      run_conv(12'd1000, 4'd1, 3'b000, 12'd1000, 1'b0, 16, "custom_1000");
      t = n_strobe + 1;
      start_conv(12'd1000, 4'd1, 3'b000, 1'b1, 12'd1000, 1'b0, 16);
      repeat (4) @(negedge clk);
      check("busy_mid_conv", 32'(busy_out), 32'h1);
      wr(0, 12'd5);
      wait_strobes(t, "busy_write");
      @(negedge clk);
      run_conv(12'd3000, 4'd1, 3'b000, 12'd3000, 1'b0, 16, "custom_3000");

      // Majority vote over 7 samples in the last step.
      ovr_arm = 1'b1;
      ovr_pat = 7'b1010101;
      run_conv(12'd999, 4'd1, 3'b010, 12'd1000, 1'b0, 40, "avg_accept");
      ovr_pat = 7'b0101010;
      run_conv(12'd1000, 4'd1, 3'b010, 12'd999, 1'b0, 40, "avg_reject");
      check("convert_len_n7", 32'(last_len), 32'd39);
      ovr_arm = 1'b0;

      // Saturation with all-ones weights.
      for (int k = 0; k < ST; k++) wr(k, 12'hFFF);
      force_one = 1'b1;
      t = n_strobe + 1;
      start_conv(12'd0, 4'd1, 3'b000, 1'b1, 12'hFFF, 1'b1, 16);
      repeat (5) @(negedge clk);
      check("nswitch_saturated", 32'(nswitch_out), 32'hFFF);
      wait_strobes(t, "saturate");
      @(negedge clk);
      force_one = 1'b0;
      for (int k = 0; k < ST; k++) wr(k, MB'(cw[k]));
      run_conv(12'd1000, 4'd1, 3'b000, 12'd1000, 1'b0, 16, "ovf_clear");

      // Continuous back-to-back conversions.
      base = n_strobe;
      ds0 = done_sample;
      for (int i = 0; i < 3; i++) exp_q.push_back('{12'd1000, 1'b0, 18});
      vin = 12'd1000;
      sample_cycles_in = 4'd3;
      avg_control_in = 3'b000;
      continuous_in = 1'b1;
      wait_strobes(base + 2, "cont_two");
      @(negedge clk);
      continuous_in = 1'b0;
      wait_strobes(base + 3, "cont_three");
      repeat (40) @(negedge clk);
      check("cont_strobe_count", 32'(n_strobe - base), 32'd3);
      check("cont_done_to_sample", 32'(done_sample - ds0), 32'd2);
      check("cont_idle_busy", 32'(busy_out), 32'h0);

      // Reset in the middle of a conversion.
      start_conv(12'h555, 4'd1, 3'b000, 1'b0, 12'h0, 1'b0, 0);
      repeat (6) @(negedge clk);
      check("pre_rst_loop", 32'(enable_loop_out), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", 32'(busy_out), 32'h0);
      check("mid_rst_result", 32'(result_out), 32'h0);
      check("mid_rst_strobe", 32'(conv_finished_strobe_out), 32'h0);
      check("mid_rst_pswitch", 32'(pswitch_out), 32'hFFF);
      check("mid_rst_loop", 32'(enable_loop_out), 32'h0);
      base = n_strobe;
      repeat (30) @(negedge clk);
      check("mid_rst_no_strobe", 32'(n_strobe), 32'(base));
      run_conv(12'hABC, 4'd1, 3'b000, 12'hABC, 1'b0, 16, "post_rst_weights");

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("inverse_outputs", 32'(inv_err), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sar_control_weighted.md
Name: sar_control_weighted

Overview:
- Parametrised successor SAR ADC control FSM. Drives the capacitor-matrix p/n switches and the sample and loop-enable signals, and accumulates the conversion result.
- Generalised in matrix width, step count and LSB-averaging depth.
- Adds a runtime-writable step-weight table, programmable sample length, single-shot/continuous trigger, result saturation and overflow flag.
- Sits between the comparator and the capacitive DAC matrix; the result feeds the OSR.

Parameters:
MATRIX_BITS, 12, DAC matrix / result width
STEPS, 15, comparison steps per conversion
LSB_STEPS, 4, final steps subject to comparator averaging (1..STEPS)
STEP_AW, 4, weight-table address width (2**STEP_AW >= STEPS)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start_in  in  1  single-shot conversion trigger (level sampled in IDLE/DONE)
continuous_in  in  1  free-running conversions while high
avg_control_in  in  3  LSB averaging count: 001=3, 010=7, 011=15, 100=31, others=1
sample_cycles_in  in  4  sample phase length in cycles, 0 treated as 1
comparator_in  in  1  1 = accept trial weight
wt_we_in  in  1  weight-table write enable
wt_addr_in  in  STEP_AW  weight-table address (step index)
wt_data_in  in  MATRIX_BITS  weight value
sample_out  out  1  sampling switch
sample_out_n  out  1  inverse of sample_out
enable_loop_out  out  1  comparator loop enable, high only in CONVERT
busy_out  out  1  high in SAMPLE, CONVERT, DONE
nswitch_out  out  MATRIX_BITS  trial code
pswitch_out  out  MATRIX_BITS  bitwise inverse of nswitch_out
result_out  out  MATRIX_BITS  last completed result
conv_finished_strobe_out  out  1  one-cycle strobe, result_out valid
overflow_out  out  1  last result saturated

Behaviour:
- Reset (sync, rst=1 at edge):
  - state IDLE; data register 0; result_out 0; strobe 0; overflow_out 0; sample_out 0; sample_out_n 1.
  - Weight table: weight[k] = 2**(MATRIX_BITS-1-k) for k<MATRIX_BITS, else 0.
  - Reset mid-conversion aborts without strobe; result_out is cleared.
- Weight writes: accepted only in IDLE. Ignored while busy_out=1 or when wt_addr_in>=STEPS.
- States:
  - IDLE: all switch outputs idle. If start_in|continuous_in, latch avg_control_in and sample_cycles_in, then go to SAMPLE.
  - SAMPLE: sample_out=1, data register cleared. Lasts S cycles (latched value, 0->1), then CONVERT at step 0.
  - CONVERT at step k:
    - trial = data + weight[k], computed MATRIX_BITS+1 wide.
    - nswitch_out = trial, saturated to all-ones on carry.
    - Steps k < STEPS-LSB_STEPS last 1 cycle; decision = comparator_in.
    - Later steps last N cycles (N from latched avg_control). ones = count of comparator_in=1 over those cycles; decision = ones >= (N+1)/2 (majority).
    - Decision 1: data <= saturated trial; if saturation occurred, set sticky conversion-overflow.
    - After step STEPS-1, go to DONE.
  - DONE (1 cycle):
    - conv_finished_strobe_out=1; result_out=data; overflow_out=sticky flag.
    - Next state: SAMPLE if start_in|continuous_in (new control latch), else IDLE.
- Outside CONVERT: nswitch_out = data register (0 in IDLE/SAMPLE).
- Weight 0 steps still consume their cycles.
- start_in during SAMPLE/CONVERT is ignored (no queueing).
- avg_control_in and sample_cycles_in changes mid-conversion have no effect.
- Latency: strobe occurs S + (STEPS-LSB_STEPS) + LSB_STEPS*N cycles after the first SAMPLE cycle.

Test Plan:
- Reset weights, comparator model (trial<=vin), vin=0xABC, S=1, N=1, start pulse -> result_out=0xABC, strobe exactly 16 cycles after first sample_out=1, overflow_out=0.
- Load weights 2048,806,486,295,180,110,67,41,25,15,9,6,4,2,1; vin=1000 -> result_out=1000; write attempted while busy leaves table unchanged.
- avg_control=010 (N=7): in step STEPS-1, comparator gives 4 ones of 7 -> accepted; 3 ones of 7 -> rejected. CONVERT length = 11+4*7 cycles.
- All weights 4095, comparator always 1 -> nswitch_out saturates to 0xFFF, result_out=0xFFF, overflow_out=1. Next normal conversion clears overflow_out.
- continuous_in=1, S=3 -> back-to-back conversions; DONE followed directly by SAMPLE; one strobe per conversion; sample_out_n always equals ~sample_out.
- rst asserted mid-CONVERT -> next cycle IDLE, result_out=0, no strobe, busy_out=0, pswitch_out=0xFFF.
